// File: rtl/pkt_filter_pkg.sv
// Shared types for the packet filter engine: protocol codes, rule table
// entries, queued header records and FSM state encoding, plus the rule
// match helpers used by the engine.
package pkt_filter_pkg;

    typedef enum logic [1:0] {
        PROTO_NONE = 2'b00,
        PROTO_TCP  = 2'b01,
        PROTO_UDP  = 2'b10,
        PROTO_ANY  = 2'b11
    } proto_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] dst_ip;
        logic [31:0] dst_mask;
        logic [15:0] dst_port;
        proto_e      proto;
        logic        accept;
    } rule_t;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        proto_e      proto;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // PROTO_ANY accepts either transport; every other code needs an exact match,
    // so a PROTO_NONE rule only catches packets that are neither TCP nor UDP.
    function automatic logic proto_match(input proto_e rule_proto, input proto_e pkt_proto);
        if (rule_proto == PROTO_ANY)
            return (pkt_proto == PROTO_TCP) || (pkt_proto == PROTO_UDP);
        return rule_proto == pkt_proto;
    endfunction

    // A port value of zero in the rule acts as a wildcard.
    function automatic logic rule_hit(input logic        r_valid,
                                      input logic [31:0] r_ip,
                                      input logic [31:0] r_mask,
                                      input logic [15:0] r_port,
                                      input proto_e      r_proto,
                                      input logic [31:0] p_ip,
                                      input logic [15:0] p_port,
                                      input proto_e      p_proto);
        return r_valid
            && ((p_ip & r_mask) == (r_ip & r_mask))
            && ((r_port == 16'd0) || (r_port == p_port))
            && proto_match(r_proto, p_proto);
    endfunction

endpackage

// File: rtl/pkt_filter_fifo.sv
// Synchronous FIFO of parsed headers. The head entry is visible on pop_data
// whenever the queue is non-empty; push is ignored when full and pop when empty.
module pkt_filter_fifo
    import pkt_filter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  hdr_t push_data,
    input  logic pop,
    output hdr_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    hdr_t           mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Entry storage, no reset needed: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Read and write pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_filter_engine.sv
// Packet filter engine: queues parser results, walks the rule table one entry
// per cycle with a fixed latency and presents an accept/drop decision on a
// valid/ready port, keeping saturating statistics.
// Optional per-rule hit counters are built when PKT_FILTER_HIT_CNT_EN is defined.
module pkt_filter_engine
    import pkt_filter_pkg::*;
#(
    parameter int NUM_RULES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  src_ip,
    input  logic [31:0]                  dst_ip,
    input  logic [15:0]                  src_port,
    input  logic [15:0]                  dst_port,
    input  logic                         is_tcp,
    input  logic                         is_udp,
    input  logic                         checksum_ok,
    input  logic                         parser_done,
    input  logic                         parser_error,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_RULES)-1:0] cfg_idx,
    input  logic                         cfg_rule_valid,
    input  logic [31:0]                  cfg_dst_ip,
    input  logic [31:0]                  cfg_dst_mask,
    input  logic [15:0]                  cfg_dst_port,
    input  logic [1:0]                   cfg_proto,
    input  logic                         cfg_accept,
    input  logic                         cfg_default_accept,
    output logic                         cfg_ready,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic                         dec_accept,
    output logic                         dec_hit,
    output logic [$clog2(NUM_RULES)-1:0] dec_rule,
    output logic [31:0]                  dec_src_ip,
    output logic [31:0]                  dec_dst_ip,
    output logic [15:0]                  dec_src_port,
    output logic [15:0]                  dec_dst_port,
    output logic [CNT_W-1:0]             cnt_accept,
    output logic [CNT_W-1:0]             cnt_drop,
    output logic [CNT_W-1:0]             cnt_bad,
    output logic [CNT_W-1:0]             cnt_ovf,
    input  logic [$clog2(NUM_RULES)-1:0] hit_cnt_idx,
    output logic [CNT_W-1:0]             hit_cnt
);

    localparam int IDX_W = $clog2(NUM_RULES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_MATCH = MATCH;
    localparam logic [1:0] S_EMIT  = EMIT;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]       state;
    logic [IDX_W-1:0] rule_idx;
    logic             hit_q;
    logic [IDX_W-1:0] hit_rule_q;
    logic             hit_acc_q;
    hdr_t             work_q;
    rule_t            rules [NUM_RULES];

    hdr_t   push_hdr;
    hdr_t   fifo_head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;
    logic   pkt_bad;
    logic   cfg_wr;
    logic   dec_fire;
    logic   cur_hit;
    rule_t  cur_rule;
    proto_e pkt_proto;

    assign pkt_bad   = parser_error || !checksum_ok;
    assign pkt_proto = is_tcp ? PROTO_TCP : (is_udp ? PROTO_UDP : PROTO_NONE);
    assign push_hdr  = '{src_ip: src_ip, dst_ip: dst_ip, src_port: src_port,
                         dst_port: dst_port, proto: pkt_proto};
    assign fifo_push = parser_done && !pkt_bad;
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign cfg_ready = (state == S_IDLE);
    assign cfg_wr    = cfg_we && cfg_ready;
    assign dec_fire  = (state == S_EMIT) && dec_ready;

    assign cur_rule = rules[rule_idx];
    assign cur_hit  = rule_hit(cur_rule.valid, cur_rule.dst_ip, cur_rule.dst_mask,
                               cur_rule.dst_port, cur_rule.proto,
                               work_q.dst_ip, work_q.dst_port, work_q.proto);

    pkt_filter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_hdr),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Rule table writes, accepted only while the matcher is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RULES; i++)
                rules[i] <= '0;
        end else if (cfg_wr) begin
            rules[cfg_idx] <= '{valid: cfg_rule_valid, dst_ip: cfg_dst_ip,
                                dst_mask: cfg_dst_mask, dst_port: cfg_dst_port,
                                proto: proto_e'(cfg_proto), accept: cfg_accept};
        end
    end

    // Working header: loaded from the queue head when the matcher starts.
    always_ff @(posedge clk) begin
        if (fifo_pop)
            work_q <= fifo_head;
    end

    // Matcher FSM: pop, scan every rule in order, then hold the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rule_idx     <= '0;
            hit_q        <= 1'b0;
            hit_rule_q   <= '0;
            hit_acc_q    <= 1'b0;
            dec_valid    <= 1'b0;
            dec_accept   <= 1'b0;
            dec_hit      <= 1'b0;
            dec_rule     <= '0;
            dec_src_ip   <= '0;
            dec_dst_ip   <= '0;
            dec_src_port <= '0;
            dec_dst_port <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= S_MATCH;
                        rule_idx   <= '0;
                        hit_q      <= 1'b0;
                        hit_rule_q <= '0;
                        hit_acc_q  <= 1'b0;
                    end
                end
                S_MATCH: begin
                    // Only the first hit is kept; the scan always runs to the end.
                    if (cur_hit && !hit_q) begin
                        hit_q      <= 1'b1;
                        hit_rule_q <= rule_idx;
                        hit_acc_q  <= cur_rule.accept;
                    end
                    rule_idx <= rule_idx + 1'b1;
                    if (rule_idx == LAST_IDX) begin
                        state        <= S_EMIT;
                        dec_valid    <= 1'b1;
                        dec_hit      <= hit_q || cur_hit;
                        dec_rule     <= hit_q ? hit_rule_q : (cur_hit ? rule_idx : '0);
                        dec_accept   <= hit_q ? hit_acc_q
                                              : (cur_hit ? cur_rule.accept : cfg_default_accept);
                        dec_src_ip   <= work_q.src_ip;
                        dec_dst_ip   <= work_q.dst_ip;
                        dec_src_port <= work_q.src_port;
                        dec_dst_port <= work_q.dst_port;
                    end
                end
                S_EMIT: begin
                    if (dec_ready) begin
                        state     <= S_IDLE;
                        dec_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    dec_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics: capture-side rejects and emitted decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_accept <= '0;
            cnt_drop   <= '0;
            cnt_bad    <= '0;
            cnt_ovf    <= '0;
        end else begin
            if (parser_done) begin
                if (pkt_bad)
                    cnt_bad <= sat_inc(cnt_bad);
                else if (fifo_full)
                    cnt_ovf <= sat_inc(cnt_ovf);
            end
            if (dec_fire) begin
                if (dec_accept)
                    cnt_accept <= sat_inc(cnt_accept);
                else
                    cnt_drop <= sat_inc(cnt_drop);
            end
        end
    end

`ifdef PKT_FILTER_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q [NUM_RULES];

    // Per-rule hit counters; rewriting a rule restarts its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RULES; i++)
                hit_cnt_q[i] <= '0;
        end else begin
            if (cfg_wr)
                hit_cnt_q[cfg_idx] <= '0;
            if (dec_fire && dec_hit)
                hit_cnt_q[dec_rule] <= sat_inc(hit_cnt_q[dec_rule]);
        end
    end

    assign hit_cnt = hit_cnt_q[hit_cnt_idx];
`else
    logic unused_hit_cnt_idx;
    assign unused_hit_cnt_idx = ^hit_cnt_idx;
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_filter_engine.sv
`timescale 1ns/1ps
module tb_pkt_filter_engine;

    localparam int NR = 4;
    localparam int FD = 4;
    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic        is_tcp, is_udp, checksum_ok, parser_done, parser_error;
    logic        cfg_we, cfg_rule_valid, cfg_accept, cfg_default_accept;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_dst_ip, cfg_dst_mask;
    logic [15:0] cfg_dst_port;
    logic [1:0]  cfg_proto;
    logic        cfg_ready;
    logic        dec_valid, dec_ready, dec_accept, dec_hit;
    logic [1:0]  dec_rule;
    logic [31:0] dec_src_ip, dec_dst_ip;
    logic [15:0] dec_src_port, dec_dst_port;
    logic [CW-1:0] cnt_accept, cnt_drop, cnt_bad, cnt_ovf, hit_cnt;
    logic [1:0]  hit_cnt_idx;

    always #5 clk = ~clk;

    pkt_filter_engine #(.NUM_RULES(NR), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .is_tcp(is_tcp), .is_udp(is_udp), .checksum_ok(checksum_ok),
        .parser_done(parser_done), .parser_error(parser_error),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rule_valid(cfg_rule_valid),
        .cfg_dst_ip(cfg_dst_ip), .cfg_dst_mask(cfg_dst_mask), .cfg_dst_port(cfg_dst_port),
        .cfg_proto(cfg_proto), .cfg_accept(cfg_accept), .cfg_default_accept(cfg_default_accept),
        .cfg_ready(cfg_ready),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_accept(dec_accept),
        .dec_hit(dec_hit), .dec_rule(dec_rule),
        .dec_src_ip(dec_src_ip), .dec_dst_ip(dec_dst_ip),
        .dec_src_port(dec_src_port), .dec_dst_port(dec_dst_port),
        .cnt_accept(cnt_accept), .cnt_drop(cnt_drop), .cnt_bad(cnt_bad), .cnt_ovf(cnt_ovf),
        .hit_cnt_idx(hit_cnt_idx), .hit_cnt(hit_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: rule table as plain arrays plus expected statistics.
    logic        m_valid [NR];
    logic [31:0] m_ip    [NR];
    logic [31:0] m_mask  [NR];
    logic [15:0] m_port  [NR];
    logic [1:0]  m_proto [NR];
    logic        m_acc   [NR];
    int e_acc = 0, e_drop = 0, e_bad = 0, e_ovf = 0;
    int e_hit [NR];

    function automatic logic [1:0] proto_of(input logic tcp, input logic udp);
        if (tcp) return 2'b01;
        if (udp) return 2'b10;
        return 2'b00;
    endfunction

    // First matching rule wins; otherwise the default action applies.
    function automatic void predict(input logic [31:0] dip, input logic [15:0] dport,
                                    input logic [1:0] pr, output logic hit,
                                    output logic [1:0] rule, output logic acc);
        logic pok;
        hit = 1'b0; rule = 2'd0; acc = cfg_default_accept;
        for (int i = 0; i < NR; i++) begin
            pok = (m_proto[i] == 2'b11) ? (pr == 2'b01 || pr == 2'b10) : (m_proto[i] == pr);
            if (!hit && m_valid[i] && ((dip & m_mask[i]) == (m_ip[i] & m_mask[i]))
                && (m_port[i] == 16'd0 || m_port[i] == dport) && pok) begin
                hit = 1'b1; rule = 2'(i); acc = m_acc[i];
            end
        end
    endfunction

    task automatic cfg_write(input int idx, input logic v, input logic [31:0] ip,
                             input logic [31:0] mask, input logic [15:0] port,
                             input logic [1:0] pr, input logic acc);
        int guard = 0;
        while (!cfg_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_rule_valid = v; cfg_dst_ip = ip;
        cfg_dst_mask = mask; cfg_dst_port = port; cfg_proto = pr; cfg_accept = acc;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_valid[idx] = v; m_ip[idx] = ip; m_mask[idx] = mask; m_port[idx] = port;
        m_proto[idx] = pr; m_acc[idx] = acc; e_hit[idx] = 0;
    endtask

    task automatic send_pkt(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sp,
                            input logic [15:0] dp, input logic tcp, input logic udp,
                            input logic ok, input logic err);
        src_ip = s; dst_ip = d; src_port = sp; dst_port = dp; is_tcp = tcp; is_udp = udp;
        checksum_ok = ok; parser_error = err; parser_done = 1'b1;
        @(posedge clk); #1;
        parser_done = 1'b0;
    endtask

    task automatic wait_dec(output int edges, output bit ok);
        edges = 0; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dec_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic handshake(input logic acc, input logic hit, input logic [1:0] rule);
        dec_ready = 1'b1;
        @(posedge clk); #1;
        dec_ready = 1'b0;
        if (acc) e_acc++; else e_drop++;
        if (hit) e_hit[rule]++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %0b expected 0", dec_valid); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
        n_cmp++; if ({dec_accept, dec_hit, dec_rule, dec_src_ip, dec_dst_ip} !== '0) begin n_fail++; $display("FAIL reset_dec_fields: got nonzero expected 0"); end
        n_cmp++; if ({cnt_accept, cnt_drop, cnt_bad, cnt_ovf} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0h expected 0", {cnt_accept, cnt_drop, cnt_bad, cnt_ovf}); end
        n_cmp++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_tcp;
        int edges; bit ok; logic h, a; logic [1:0] r;
        cfg_default_accept = 1'b0;
        cfg_write(0, 1'b1, 32'hC0A80002, 32'hFFFFFFFF, 16'h0090, 2'b01, 1'b1);
        send_pkt(32'hC0A80001, 32'hC0A80002, 16'h1111, 16'h0090, 1'b1, 1'b0, 1'b1, 1'b0);
        predict(32'hC0A80002, 16'h0090, 2'b01, h, r, a);
        wait_dec(edges, ok);
        n_cmp++; if (!ok || edges != NR + 1) begin n_fail++; $display("FAIL basic_latency: got %0d edges (valid=%0b) expected %0d", edges, ok, NR + 1); end
        n_cmp++; if ({dec_accept, dec_hit, dec_rule} !== {1'b1, 1'b1, 2'd0} || {dec_accept, dec_hit, dec_rule} !== {a, h, r}) begin n_fail++; $display("FAIL basic_decision: got acc=%0b hit=%0b rule=%0d expected 1 1 0", dec_accept, dec_hit, dec_rule); end
        n_cmp++; if (dec_src_ip !== 32'hC0A80001 || dec_dst_ip !== 32'hC0A80002 || dec_src_port !== 16'h1111 || dec_dst_port !== 16'h0090) begin n_fail++; $display("FAIL basic_header: got %h->%h expected c0a80001->c0a80002", dec_src_ip, dec_dst_ip); end
        handshake(a, h, r);
        n_cmp++; if (dec_valid !== 1'b0 || cnt_accept !== CW'(e_acc)) begin n_fail++; $display("FAIL basic_cnt_accept: got valid=%0b cnt=%0d expected 0 %0d", dec_valid, cnt_accept, e_acc); end
    endtask

    task automatic test_udp_and_none;
        int edges; bit ok; logic h, a; logic [1:0] r;
        send_pkt(32'hC0A80001, 32'hC0A80002, 16'h2222, 16'h0090, 1'b0, 1'b1, 1'b1, 1'b0);
        predict(32'hC0A80002, 16'h0090, 2'b10, h, r, a);
        wait_dec(edges, ok);
        n_cmp++; if (!ok || {dec_hit, dec_accept, dec_rule} !== {1'b0, 1'b0, 2'd0} || {dec_hit, dec_accept} !== {h, a}) begin n_fail++; $display("FAIL udp_nohit: got valid=%0b hit=%0b acc=%0b rule=%0d expected 1 0 0 0", ok, dec_hit, dec_accept, dec_rule); end
        handshake(a, h, r);
        n_cmp++; if (cnt_drop !== CW'(e_drop)) begin n_fail++; $display("FAIL udp_cnt_drop: got %0d expected %0d", cnt_drop, e_drop); end
        cfg_write(1, 1'b1, 32'hC0A80002, 32'hFFFFFFFF, 16'h0000, 2'b00, 1'b1);
        send_pkt(32'hC0A80001, 32'hC0A80002, 16'h0000, 16'h0090, 1'b0, 1'b0, 1'b1, 1'b0);
        predict(32'hC0A80002, 16'h0090, 2'b00, h, r, a);
        wait_dec(edges, ok);
        n_cmp++; if (!ok || {dec_hit, dec_rule, dec_accept} !== {1'b1, 2'd1, 1'b1} || {dec_hit, dec_rule, dec_accept} !== {h, r, a}) begin n_fail++; $display("FAIL noproto_rule1: got valid=%0b hit=%0b rule=%0d acc=%0b expected 1 1 1 1", ok, dec_hit, dec_rule, dec_accept); end
        handshake(a, h, r);
    endtask

    task automatic test_bad;
        int seen = 0;
        send_pkt(32'h01010101, 32'hC0A80002, 16'h1, 16'h0090, 1'b1, 1'b0, 1'b1, 1'b1);
        send_pkt(32'h02020202, 32'hC0A80002, 16'h1, 16'h0090, 1'b1, 1'b0, 1'b0, 1'b0);
        e_bad += 2;
        for (int i = 0; i < 12; i++) begin
            if (dec_valid) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL bad_no_decision: got %0d valid cycles expected 0", seen); end
        n_cmp++; if (cnt_bad !== CW'(e_bad)) begin n_fail++; $display("FAIL bad_cnt: got %0d expected %0d", cnt_bad, e_bad); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_src [$];
        logic        exp_a   [$];
        logic        exp_h   [$];
        logic [1:0]  exp_r   [$];
        logic h, a; logic [1:0] r;
        int got = 0;
        dec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src_ip = 32'h0B000000 + i; dst_ip = 32'hC0A80002; src_port = 16'(i);
            dst_port = 16'h0090; is_tcp = (i % 2 == 0); is_udp = (i % 2 == 1);
            checksum_ok = 1'b1; parser_error = 1'b0; parser_done = 1'b1;
            predict(32'hC0A80002, 16'h0090, proto_of(is_tcp, is_udp), h, r, a);
            if (i < 5) begin exp_src.push_back(src_ip); exp_a.push_back(a); exp_h.push_back(h); exp_r.push_back(r); end
            @(posedge clk); #1;
        end
        parser_done = 1'b0;
        e_ovf++;
        repeat (8) begin @(posedge clk); #1; end
        n_cmp++; if (dec_valid !== 1'b1 || dec_src_ip !== exp_src[0]) begin n_fail++; $display("FAIL ovf_first_held: got valid=%0b src=%h expected 1 %h", dec_valid, dec_src_ip, exp_src[0]); end
        n_cmp++; if (cnt_ovf !== CW'(e_ovf)) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected %0d", cnt_ovf, e_ovf); end
        dec_ready = 1'b1;
        for (int c = 0; c < 80 && got < 5; c++) begin
            if (dec_valid) begin
                n_cmp++;
                if (dec_src_ip !== exp_src[got] || dec_accept !== exp_a[got] || dec_hit !== exp_h[got] || dec_rule !== exp_r[got]) begin
                    n_fail++; $display("FAIL ovf_order_%0d: got src=%h acc=%0b expected src=%h acc=%0b", got, dec_src_ip, dec_accept, exp_src[got], exp_a[got]);
                end
                if (exp_a[got]) e_acc++; else e_drop++;
                if (exp_h[got]) e_hit[exp_r[got]]++;
                got++;
            end
            @(posedge clk); #1;
        end
        dec_ready = 1'b0;
        n_cmp++; if (got != 5) begin n_fail++; $display("FAIL ovf_count: got %0d decisions expected 5", got); end
        n_cmp++; if (cnt_accept !== CW'(e_acc) || cnt_drop !== CW'(e_drop)) begin n_fail++; $display("FAIL ovf_stats: got acc=%0d drop=%0d expected %0d %0d", cnt_accept, cnt_drop, e_acc, e_drop); end
    endtask

    task automatic test_overlap_and_cfg_block;
        int edges; bit ok; logic h, a; logic [1:0] r;
        cfg_write(1, 1'b1, 32'hC0000000, 32'hFF000000, 16'h0000, 2'b11, 1'b0);
        cfg_write(3, 1'b1, 32'hC0A80005, 32'hFFFFFFFF, 16'h1234, 2'b01, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            send_pkt(32'h0A0A0A0A, 32'hC0A80005, 16'h5555, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
            predict(32'hC0A80005, 16'h1234, 2'b01, h, r, a);
            if (pass == 0) begin
                @(posedge clk); #1;
                n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL match_cfg_ready: got %0b expected 0", cfg_ready); end
                cfg_we = 1'b1; cfg_idx = 2'd1; cfg_rule_valid = 1'b0; cfg_dst_ip = 32'h0;
                cfg_dst_mask = 32'h0; cfg_dst_port = 16'h0; cfg_proto = 2'b00; cfg_accept = 1'b1;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
            wait_dec(edges, ok);
            n_cmp++; if (!ok || {dec_hit, dec_rule, dec_accept} !== {1'b1, 2'd1, 1'b0} || {dec_hit, dec_rule, dec_accept} !== {h, r, a}) begin n_fail++; $display("FAIL overlap_pass%0d: got valid=%0b hit=%0b rule=%0d acc=%0b expected 1 1 1 0", pass, ok, dec_hit, dec_rule, dec_accept); end
            handshake(a, h, r);
        end
    endtask

    task automatic test_hit_cnt;
        int edges; bit ok; logic h, a; logic [1:0] r;
        cfg_write(0, 1'b0, 32'h0, 32'h0, 16'h0, 2'b00, 1'b0);
        cfg_write(1, 1'b0, 32'h0, 32'h0, 16'h0, 2'b00, 1'b0);
        cfg_write(2, 1'b1, 32'h0A000001, 32'hFFFFFFFF, 16'h0000, 2'b10, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send_pkt(32'h0C000000 + k, 32'h0A000001, 16'h100, 16'(53 + k), 1'b0, 1'b1, 1'b1, 1'b0);
            predict(32'h0A000001, 16'(53 + k), 2'b10, h, r, a);
            wait_dec(edges, ok);
            n_cmp++; if (!ok || dec_rule !== 2'd2 || dec_hit !== h) begin n_fail++; $display("FAIL hit_rule2_%0d: got valid=%0b rule=%0d expected 1 2", k, ok, dec_rule); end
            handshake(a, h, r);
        end
        hit_cnt_idx = 2'd2; #1;
`ifdef PKT_FILTER_HIT_CNT_EN
        n_cmp++; if (hit_cnt !== CW'(3) || hit_cnt !== CW'(e_hit[2])) begin n_fail++; $display("FAIL hit_cnt_rule2: got %0d expected 3", hit_cnt); end
`else
        n_cmp++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL hit_cnt_tied: got %0d expected 0", hit_cnt); end
`endif
        hit_cnt_idx = 2'd0; #1;
        n_cmp++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL hit_cnt_cleared: got %0d expected 0", hit_cnt); end
    endtask

    task automatic test_random;
        int edges; bit ok; logic h, a; logic [1:0] r;
        logic [31:0] pool [5];
        logic [31:0] masks [4];
        logic [15:0] ports [3];
        logic [31:0] d; logic [15:0] dp; logic tcp, udp; int pick;
        pool[0] = 32'hC0A80001; pool[1] = 32'hC0A80002; pool[2] = 32'hC0A80103;
        pool[3] = 32'h0A000001; pool[4] = 32'hC0000009;
        masks[0] = 32'hFFFFFFFF; masks[1] = 32'hFFFFFF00; masks[2] = 32'hFF000000; masks[3] = 32'h0;
        ports[0] = 16'd0; ports[1] = 16'd80; ports[2] = 16'd443;
        for (int k = 0; k < NR; k++)
            cfg_write(k, ($urandom_range(0, 3) != 0), pool[$urandom_range(0, 4)],
                      masks[$urandom_range(0, 3)], ports[$urandom_range(0, 2)],
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        cfg_default_accept = 1'($urandom_range(0, 1));
        for (int n = 0; n < 25; n++) begin
            d = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 4)];
            dp = ($urandom_range(0, 2) == 0) ? 16'd22 : ports[$urandom_range(1, 2)];
            pick = $urandom_range(0, 2); tcp = (pick == 0); udp = (pick == 1);
            predict(d, dp, proto_of(tcp, udp), h, r, a);
            send_pkt(32'(n), d, 16'(n), dp, tcp, udp, 1'b1, 1'b0);
            wait_dec(edges, ok);
            n_cmp++; if (!ok || dec_accept !== a || dec_hit !== h || dec_rule !== r || dec_dst_ip !== d || dec_dst_port !== dp) begin
                n_fail++; $display("FAIL rand_%0d: got valid=%0b acc=%0b hit=%0b rule=%0d expected acc=%0b hit=%0b rule=%0d", n, ok, dec_accept, dec_hit, dec_rule, a, h, r);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            n_cmp++; if (dec_valid !== 1'b1 || dec_src_ip !== 32'(n)) begin n_fail++; $display("FAIL rand_hold_%0d: got valid=%0b src=%h expected 1 %h", n, dec_valid, dec_src_ip, 32'(n)); end
            handshake(a, h, r);
        end
        n_cmp++; if (cnt_accept !== CW'(e_acc) || cnt_drop !== CW'(e_drop) || cnt_bad !== CW'(e_bad) || cnt_ovf !== CW'(e_ovf)) begin
            n_fail++; $display("FAIL rand_stats: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", cnt_accept, cnt_drop, cnt_bad, cnt_ovf, e_acc, e_drop, e_bad, e_ovf);
        end
        for (int k = 0; k < NR; k++) begin
            hit_cnt_idx = 2'(k); #1;
`ifdef PKT_FILTER_HIT_CNT_EN
            n_cmp++; if (hit_cnt !== CW'(e_hit[k])) begin n_fail++; $display("FAIL rand_hit_cnt_%0d: got %0d expected %0d", k, hit_cnt, e_hit[k]); end
`else
            n_cmp++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL rand_hit_cnt_%0d: got %0d expected 0", k, hit_cnt); end
`endif
        end
    endtask

    task automatic test_reset_mid_emit;
        int edges; bit ok; int seen = 0;
        cfg_write(0, 1'b1, 32'hC0A80002, 32'hFFFFFFFF, 16'h0090, 2'b01, 1'b1);
        send_pkt(32'hC0A80001, 32'hC0A80002, 16'h1, 16'h0090, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_dec(edges, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_emit_setup: got valid=0 expected 1"); end
        rst_n = 1'b0; #1;
        n_cmp++; if (dec_valid !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_emit_ctrl: got valid=%0b ready=%0b expected 0 1", dec_valid, cfg_ready); end
        n_cmp++; if ({cnt_accept, cnt_drop, cnt_bad, cnt_ovf, hit_cnt} !== '0) begin n_fail++; $display("FAIL rst_emit_counters: got nonzero expected 0"); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (dec_valid) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0 || cnt_accept !== '0) begin n_fail++; $display("FAIL rst_emit_discard: got %0d valid cycles cnt=%0d expected 0 0", seen, cnt_accept); end
    endtask

    initial begin
        src_ip = '0; dst_ip = '0; src_port = '0; dst_port = '0;
        is_tcp = 0; is_udp = 0; checksum_ok = 1; parser_done = 0; parser_error = 0;
        cfg_we = 0; cfg_idx = '0; cfg_rule_valid = 0; cfg_dst_ip = '0; cfg_dst_mask = '0;
        cfg_dst_port = '0; cfg_proto = '0; cfg_accept = 0; cfg_default_accept = 0;
        dec_ready = 0; hit_cnt_idx = '0;
        for (int i = 0; i < NR; i++) begin
            m_valid[i] = 0; m_ip[i] = '0; m_mask[i] = '0; m_port[i] = '0;
            m_proto[i] = '0; m_acc[i] = 0; e_hit[i] = 0;
        end
        test_reset();
        test_basic_tcp();
        test_udp_and_none();
        test_bad();
        test_overflow();
        test_overlap_and_cfg_block();
        test_hit_cnt();
        test_random();
        test_reset_mid_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
